// File: rtl/updown_counter_chain_if.sv
// ----------------------------------------------------------------------------
// updown_counter_chain_if
//   Bundles the command and status signals of one up/down counter chain.
//   The master drives commands and observes status. The slave is the counter.
//
//   Commands (master -> slave):
//     i_ena   clock enable for clear/load/step
//     i_clr   synchronous clear
//     i_wr    synchronous parallel load of i_in
//     i_in    load value, DIGITS*DW bits, digit 0 in the LSBs
//     i_up    count up one step
//     i_down  count down one step
//   Status (slave -> master):
//     o_q       current count, same packing as i_in
//     o_carry   1-cycle pulse when the chain wraps from all-max to zero
//     o_borrow  1-cycle pulse when the chain wraps from zero to all-max
//     o_max     every digit is at its modulus-1
//     o_zero    every digit is zero
// ----------------------------------------------------------------------------
interface updown_counter_chain_if #(
  parameter int DIGITS = 2,
  parameter int DW     = 4
);
  logic                 i_ena;
  logic                 i_clr;
  logic                 i_wr;
  logic [DIGITS*DW-1:0] i_in;
  logic                 i_up;
  logic                 i_down;
  logic [DIGITS*DW-1:0] o_q;
  logic                 o_carry;
  logic                 o_borrow;
  logic                 o_max;
  logic                 o_zero;

  modport master (
    output i_ena, i_clr, i_wr, i_in, i_up, i_down,
    input  o_q, o_carry, o_borrow, o_max, o_zero
  );

  modport slave (
    input  i_ena, i_clr, i_wr, i_in, i_up, i_down,
    output o_q, o_carry, o_borrow, o_max, o_zero
  );
endinterface

// File: rtl/updown_counter_chain.sv
// ----------------------------------------------------------------------------
// updown_counter_chain
//   A chain of DIGITS cascaded up/down digit counters. Each digit has its own
//   modulus, so one instance can hold a mixed-radix field such as mm:ss.
//   Carry and borrow between digits resolve within the same clock. Wraps of
//   the whole chain raise the registered o_carry / o_borrow pulses, which can
//   drive the next chain.
//
//   Parameters:
//     DIGITS    number of digits, digit 0 is least significant
//     DW        bits per digit
//     MODS      packed per-digit modulus, DW bits per digit; a field of 0
//               means 2**DW
//     SATURATE  0: wrap at chain extremes, 1: hold at all-max / all-zero
//
//   Ports:
//     i_clk      clock, rising edge
//     i_reset_n  asynchronous reset, active low
//     bus        slave side of updown_counter_chain_if (commands in, status out)
// ----------------------------------------------------------------------------
module updown_counter_chain #(
  parameter int                   DIGITS   = 2,
  parameter int                   DW       = 4,
  parameter logic [DIGITS*DW-1:0] MODS     = 8'h6A,
  parameter bit                   SATURATE = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  updown_counter_chain_if.slave     bus
);

  localparam int W = DIGITS * DW;

  // Largest legal value of digit k. A modulus field of 0 stands for 2**DW,
  // and 0 - 1 in DW bits gives all-ones, which is exactly that digit's max.
  function automatic logic [DW-1:0] digit_max(input int k);
    logic [DW-1:0] field;
    field = MODS[k*DW +: DW];
    return field - DW'(1);
  endfunction

  logic [W-1:0]      r_q;
  logic              r_carry;
  logic              r_borrow;

  logic [DIGITS-1:0] w_dig_max;
  logic [DIGITS-1:0] w_dig_zero;
  // w_run_up[k]: digits below k are all at max, so digit k advances on an up
  // step. w_run_dn[k] is the matching all-zero condition for down steps.
  logic [DIGITS:0]   w_run_up;
  logic [DIGITS:0]   w_run_dn;
  logic [W-1:0]      w_q_up;
  logic [W-1:0]      w_q_dn;
  logic [W-1:0]      w_load;
  logic              w_all_max;
  logic              w_all_zero;
  logic              w_step_up;
  logic              w_step_dn;
  logic [W-1:0]      w_q_next;
  logic              w_carry_next;
  logic              w_borrow_next;

  assign w_run_up[0] = 1'b1;
  assign w_run_dn[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    localparam logic [DW-1:0] MAXV = digit_max(k);

    logic [DW-1:0] w_dig;
    logic [DW-1:0] w_in_dig;

    assign w_dig         = r_q[k*DW +: DW];
    assign w_in_dig      = bus.i_in[k*DW +: DW];
    assign w_dig_max[k]  = (w_dig == MAXV);
    assign w_dig_zero[k] = (w_dig == '0);

    assign w_run_up[k+1] = w_run_up[k] & w_dig_max[k];
    assign w_run_dn[k+1] = w_run_dn[k] & w_dig_zero[k];

    // Each digit wraps inside its own modulus, so it never leaves 0..MAXV.
    assign w_q_up[k*DW +: DW] = !w_run_up[k] ? w_dig :
                                w_dig_max[k] ? '0    : w_dig + DW'(1);
    assign w_q_dn[k*DW +: DW] = !w_run_dn[k] ? w_dig :
                                w_dig_zero[k] ? MAXV : w_dig - DW'(1);

    // Out-of-range load fields clamp to the digit maximum.
    assign w_load[k*DW +: DW] = (w_in_dig > MAXV) ? MAXV : w_in_dig;
  end

  assign w_all_max  = w_run_up[DIGITS];
  assign w_all_zero = w_run_dn[DIGITS];
  assign w_step_up  = bus.i_up & ~bus.i_down;
  assign w_step_dn  = bus.i_down & ~bus.i_up;

  // Command priority: clear, then load, then a single up or down step.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_q_next      = r_q;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    if (bus.i_ena) begin
      if (bus.i_clr) begin
        w_q_next = '0;
      end else if (bus.i_wr) begin
        w_q_next = w_load;
      end else if (w_step_up) begin
        if (!(w_all_max && SATURATE)) begin
          w_q_next     = w_q_up;
          w_carry_next = w_all_max;
        end
      end else if (w_step_dn) begin
        if (!(w_all_zero && SATURATE)) begin
          w_q_next      = w_q_dn;
          w_borrow_next = w_all_zero;
        end
      end
    end
  end

  // The pulse registers load their next value on every edge, independent of
  // i_ena, so a pulse never lasts more than one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_q      <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_q      <= w_q_next;
      r_carry  <= w_carry_next;
      r_borrow <= w_borrow_next;
    end
  end

  assign bus.o_q      = r_q;
  assign bus.o_carry  = r_carry;
  assign bus.o_borrow = r_borrow;
  assign bus.o_max    = &w_dig_max;
  assign bus.o_zero   = (r_q == '0);

endmodule

// File: tb/tb_updown_counter_chain.sv
// ----------------------------------------------------------------------------
// tb_updown_counter_chain
//   Drives two chains with identical stimulus: a wrapping one (SATURATE=0) and
//   a saturating one (SATURATE=1), both 2 digits, DW=4, MODS=8'h6A (0..59).
//   The reference model tracks each chain as one integer in 0..N-1. It
//   converts to and from the packed mixed-radix digits only for comparison.
// ----------------------------------------------------------------------------
module tb_updown_counter_chain;

  localparam int          DIGITS = 2;
  localparam int          DW     = 4;
  localparam int          W      = DIGITS * DW;
  localparam logic [7:0]  MODS_P = 8'h6A;

  logic clk;
  logic rst_n;

  updown_counter_chain_if #(.DIGITS(DIGITS), .DW(DW)) bus0 ();
  updown_counter_chain_if #(.DIGITS(DIGITS), .DW(DW)) bus1 ();

  updown_counter_chain #(.DIGITS(DIGITS), .DW(DW), .MODS(MODS_P), .SATURATE(1'b0)) u_wrap (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus0)
  );

  updown_counter_chain #(.DIGITS(DIGITS), .DW(DW), .MODS(MODS_P), .SATURATE(1'b1)) u_sat (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference state: index 0 = wrapping chain, index 1 = saturating chain.
  int m_v [2];
  bit m_c [2];
  bit m_b [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int dmod(input int k);
    logic [DW-1:0] f;
    f = MODS_P[k*DW +: DW];
    return (f == 0) ? (1 << DW) : int'(f);
  endfunction

  function automatic int total_n();
    int n;
    n = 1;
    for (int k = 0; k < DIGITS; k++) n *= dmod(k);
    return n;
  endfunction

  function automatic logic [W-1:0] from_int(input int v);
    logic [W-1:0] q;
    q = '0;
    for (int k = 0; k < DIGITS; k++) begin
      q[k*DW +: DW] = DW'(v % dmod(k));
      v = v / dmod(k);
    end
    return q;
  endfunction

  // Clamp every field to its digit range, then read as a mixed-radix number.
  function automatic int load_int(input logic [W-1:0] in);
    int v, w, d;
    v = 0;
    w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(in[k*DW +: DW]);
      if (d >= dmod(k)) d = dmod(k) - 1;
      v += d * w;
      w *= dmod(k);
    end
    return v;
  endfunction

  task automatic model_edge(input logic ena, clr, wr, input logic [W-1:0] in,
                            input logic up, down);
    int n;
    n = total_n();
    for (int d = 0; d < 2; d++) begin
      m_c[d] = 1'b0;
      m_b[d] = 1'b0;
      if (ena) begin
        if (clr) m_v[d] = 0;
        else if (wr) m_v[d] = load_int(in);
        else if (up && !down) begin
          if (m_v[d] == n - 1) begin
            if (d == 0) begin m_v[d] = 0; m_c[d] = 1'b1; end
          end else m_v[d] = m_v[d] + 1;
        end else if (down && !up) begin
          if (m_v[d] == 0) begin
            if (d == 0) begin m_v[d] = n - 1; m_b[d] = 1'b1; end
          end else m_v[d] = m_v[d] - 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0;
      m_c[d] = 1'b0;
      m_b[d] = 1'b0;
    end
  endtask

  task automatic check_model();
    int n;
    n = total_n();
    check("wrap_q",      32'(bus0.o_q),      32'(from_int(m_v[0])));
    check("wrap_carry",  32'(bus0.o_carry),  32'(m_c[0]));
    check("wrap_borrow", 32'(bus0.o_borrow), 32'(m_b[0]));
    check("wrap_max",    32'(bus0.o_max),    32'(m_v[0] == n - 1));
    check("wrap_zero",   32'(bus0.o_zero),   32'(m_v[0] == 0));
    check("sat_q",       32'(bus1.o_q),      32'(from_int(m_v[1])));
    check("sat_carry",   32'(bus1.o_carry),  32'(m_c[1]));
    check("sat_borrow",  32'(bus1.o_borrow), 32'(m_b[1]));
    check("sat_max",     32'(bus1.o_max),    32'(m_v[1] == n - 1));
    check("sat_zero",    32'(bus1.o_zero),   32'(m_v[1] == 0));
  endtask

  task automatic drive(input logic ena, clr, wr, input logic [W-1:0] in,
                       input logic up, down);
    bus0.i_ena = ena; bus0.i_clr = clr; bus0.i_wr = wr;
    bus0.i_in  = in;  bus0.i_up  = up;  bus0.i_down = down;
    bus1.i_ena = ena; bus1.i_clr = clr; bus1.i_wr = wr;
    bus1.i_in  = in;  bus1.i_up  = up;  bus1.i_down = down;
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, and compare 1 time unit later.
  task automatic step(input logic ena, clr, wr, input logic [W-1:0] in,
                      input logic up, down);
    @(negedge clk);
    drive(ena, clr, wr, in, up, down);
    @(posedge clk);
    model_edge(ena, clr, wr, in, up, down);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       ena, clr, wr;
    logic [7:0] in;
    logic       up, down;
    logic [7:0] exp_q;
    logic       exp_c, exp_b;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [7:0] rin;

    // Directed vectors for the wrapping chain; expectations written by hand.
    //            ena   clr   wr    in     up    down  exp_q  c     b
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h59, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h59, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h7C, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h58, 1'b0, 1'b0};

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_reset();
    #3;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].ena, vecs[i].clr, vecs[i].wr, vecs[i].in, vecs[i].up, vecs[i].down);
      check($sformatf("tbl%0d_q", i),      32'(bus0.o_q),      32'(vecs[i].exp_q));
      check($sformatf("tbl%0d_carry", i),  32'(bus0.o_carry),  32'(vecs[i].exp_c));
      check($sformatf("tbl%0d_borrow", i), 32'(bus0.o_borrow), 32'(vecs[i].exp_b));
    end

    // Saturating chain holds at both extremes without pulses.
    step(1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_hold_max_q",     32'(bus1.o_q),     32'h59);
    check("sat_hold_max_carry", 32'(bus1.o_carry), 32'h0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("sat_hold_zero_q",      32'(bus1.o_q),      32'h00);
    check("sat_hold_zero_borrow", 32'(bus1.o_borrow), 32'h0);

    // Asynchronous reset between edges: count at 57, then reset mid-cycle.
    step(1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_reset_q", 32'(bus0.o_q), 32'h57);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_q",     32'(bus0.o_q),     32'h00);
    check("async_reset_sat_q", 32'(bus1.o_q),     32'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset drops a live carry pulse.
    step(1'b1, 1'b0, 1'b1, 8'h59, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_carry",  32'(bus0.o_carry),  32'h0);
    check("async_reset_borrow", 32'(bus0.o_borrow), 32'h0);
    check("async_reset_q2",     32'(bus0.o_q),      32'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stimulus against the model; loads favour the extremes.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rin = 8'h59;
        1:       rin = 8'h00;
        default: rin = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0,
           rin,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
